// File: rtl/asu_riscv_divider_pkg.sv
// Shared definitions for the multi-cycle RISC-V M-extension divider:
// op encodings, FSM states and divider constants.
package asu_riscv_divider_pkg;

  localparam int unsigned DIV_STEPS    = 32;
  localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } div_state_e;

  function automatic logic [31:0] cond_neg(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/asu_riscv_divider_step.sv
// One restoring radix-2 division step: shift in the next dividend bit,
// trial-subtract the divisor and restore on borrow.
module asu_div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    diff    = shifted - {1'b0, div_i};
    // Partial remainder stays below the divisor, so the top bit is a clean borrow flag.
    if (!diff[XLEN]) begin
      rem_o = diff[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = shifted[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/asu_riscv_divider.sv
// Iterative 32-bit divider for DIV/DIVU/REM/REMU with valid/ready handshakes.
// Optional macro ASU_DIV_EARLY_EXIT_EN short-cuts |dividend| < |divisor|.
module asu_riscv_divider
  import asu_riscv_divider_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            kill_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  div_state_e      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d;
  logic [5:0]      cnt_q, cnt_d;

  logic [XLEN-1:0] step_rem, step_quo;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            signed_op, sa, sb;

  asu_div_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (div_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    res_d     = res_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    cnt_d     = cnt_q;
    signed_op = (op_q == OP_DIV) || (op_q == OP_REM);
    sa        = signed_op & a_q[XLEN-1];
    sb        = signed_op & b_q[XLEN-1];
    abs_a     = cond_neg(sa, a_q);
    abs_b     = cond_neg(sb, b_q);

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          state_d = S_PREP;
          op_d    = op_i;
          a_d     = op_a_i;
          b_d     = op_b_i;
        end
      end
      S_PREP: begin
        div_d   = abs_b;
        rem_d   = '0;
        quo_d   = abs_a;
        qneg_d  = sa ^ sb;
        rneg_d  = sa;
        cnt_d   = '0;
        state_d = S_ITER;
        // Special cases preload final values and pass through FIX with signs cleared.
        if (b_q == '0) begin
          quo_d   = '1;
          rem_d   = a_q;
          qneg_d  = 1'b0;
          rneg_d  = 1'b0;
          state_d = S_FIX;
        end else if (signed_op && (a_q == OVF_DIVIDEND) && (b_q == '1)) begin
          quo_d   = OVF_DIVIDEND;
          rem_d   = '0;
          qneg_d  = 1'b0;
          rneg_d  = 1'b0;
          state_d = S_FIX;
        end
`ifdef ASU_DIV_EARLY_EXIT_EN
        else if (abs_a < abs_b) begin
          quo_d   = '0;
          rem_d   = a_q;
          qneg_d  = 1'b0;
          rneg_d  = 1'b0;
          state_d = S_FIX;
        end
`else
`endif
      end
      S_ITER: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(DIV_STEPS - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        res_d   = op_q[1] ? cond_neg(rneg_q, rem_q) : cond_neg(qneg_q, quo_q);
        state_d = S_DONE;
      end
      S_DONE: begin
        if (res_ready_i) begin
          state_d = S_IDLE;
          res_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (kill_i) begin
      state_d = S_IDLE;
      res_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      res_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      res_q   <= res_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign res_valid_o = (state_q == S_DONE);
  assign result_o    = res_valid_o ? res_q : '0;

endmodule

// File: doc/asu_riscv_divider.md
ASU_RISCV_DIVIDER -- requirements
Module: asu_riscv_divider

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width (only 32 is supported).
REQ-002 SHALL have port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: nrst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid_i  in  1  request present.
REQ-005 SHALL have port: req_ready_o  out  1  divider can accept; high only in IDLE.
REQ-006 SHALL have port: op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 SHALL have ports: op_a_i  in  32  dividend; op_b_i  in  32  divisor.
REQ-008 SHALL have port: kill_i  in  1  pipeline flush; abandons any in-flight operation.
REQ-009 SHALL have ports: res_valid_o  out  1  result valid; res_ready_i  in  1  consumer accepts.
REQ-010 SHALL have ports: result_o  out  32  quotient or remainder; busy_o  out  1  high in any non-IDLE state.

Function
REQ-011 SHALL accept a request on an edge where req_valid_i and req_ready_o are both high; it SHALL register op_i, op_a_i and op_b_i at that edge (edge E0).
REQ-012 SHALL implement the FSM IDLE -> PREP -> ITER -> FIX -> DONE -> IDLE.
REQ-013 PREP (1 cycle) SHALL take magnitudes of signed operands, record the quotient sign (sign_a XOR sign_b) and remainder sign (sign_a), and detect special cases.
REQ-014 ITER SHALL run exactly 32 restoring radix-2 steps, one quotient bit per cycle, MSB first, with a 6-bit step counter.
REQ-015 FIX (1 cycle) SHALL negate the quotient or remainder if its recorded sign is negative, and select the quotient (DIV/DIVU) or remainder (REM/REMU).
REQ-016 Normal-case latency: DONE SHALL be entered at E34, with res_valid_o high from E34 onward.
REQ-017 Divide by zero SHALL go PREP -> DONE (res_valid_o high from E2) with quotient 0xFFFFFFFF and remainder op_a_i unchanged, for both signed and unsigned ops.
REQ-018 Signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM) SHALL go PREP -> DONE at E2 with quotient 0x80000000 and remainder 0.
REQ-019 In DONE, result_o and res_valid_o SHALL hold stable until res_ready_i is high; the FSM SHALL return to IDLE on that edge.
REQ-020 The FSM SHALL NOT accept a new request in the same cycle as the handoff; the earliest next acceptance is the edge after the return to IDLE.
REQ-021 kill_i high in any state SHALL force IDLE at the next edge, clear res_valid_o and discard the result; kill_i has priority over res_ready_i and over acceptance.
REQ-022 result_o SHALL be 0 whenever res_valid_o is low.

Reset
REQ-023 While nrst is low: state = IDLE, res_valid_o = 0, busy_o = 0, result_o = 0 and all internal registers = 0; req_ready_o SHALL be 1.
REQ-024 Reset asserted mid-operation SHALL abort the operation with no result ever presented.

Configuration
REQ-025 With ASU_DIV_EARLY_EXIT_EN defined: when |dividend| < |divisor| (divisor nonzero), PREP SHALL go to DONE at E2 with quotient 0 and remainder op_a_i.
REQ-026 Without ASU_DIV_EARLY_EXIT_EN, those cases SHALL take the full 34-edge path with identical results.

Structure
REQ-027 A shared package SHALL hold the op_i encodings, the FSM state enum, and the constants DIV_STEPS = 32 and the overflow dividend 0x80000000.
REQ-028 One sub-module asu_div_step SHALL implement the combinational shift/subtract/restore step; the FSM and the sign fix-up stay in the top.

Verification
REQ-029 DIVU 100 / 7 -> result 14, res_valid_o at E34; REMU 100 / 7 -> 2.
REQ-030 DIV 0xFFFFFF9C (-100) / 7 -> 0xFFFFFFF2 (-14); REM -> 0xFFFFFFFE (-2).
REQ-031 DIV 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5; both valid at E2.
REQ-032 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; both valid at E2.
REQ-033 res_ready_i held low 10 cycles after DONE -> result stable and req_ready_o low throughout; kill_i pulsed at E10 of a DIVU -> IDLE at E11 and no res_valid_o.
REQ-034 DIVU 3 / 10 -> quotient 0, valid at E2 with ASU_DIV_EARLY_EXIT_EN and at E34 without it; nrst pulsed at E5 -> all outputs 0 immediately.
